// File: rtl/decode.sv
// decode: ARM7 decode stage - condition check, register reads, operand formation, issue to execute
module decode #(
    parameter logic [31:0] PC_OFFSET = 32'd12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        decode_en,
    input  logic [31:0] instr,
    input  logic [3:0]  cpsr_flags,
    output logic        busy,
    output logic        reg_read_en,
    output logic [3:0]  reg_read_reg,
    input  logic [31:0] reg_read_value,
    output logic        exec_en,
    input  logic        exec_busy,
    output logic [1:0]  exec_class,
    output logic [3:0]  exec_op,
    output logic [5:0]  exec_ctrl,
    output logic [3:0]  exec_rd,
    output logic [31:0] exec_op1,
    output logic [31:0] exec_op2,
    output logic [1:0]  exec_shift_type,
    output logic [4:0]  exec_shift_amt,
    output logic [31:0] exec_store_data
);
    localparam logic [2:0] IDLE = 3'd0, COND = 3'd1, RD_RN = 3'd2, RD_RM = 3'd3,
                           RD_RD = 3'd4, ISSUE = 3'd5, RELEASE = 3'd6;

    logic [2:0]  state, nxt, after_cond, after_rn, after_rm;
    logic [31:0] ir, rn_val, rm_val, rd_val, rn_v, rm_v, rd_v, rdata, imm, rot_imm, boff, op2;
    logic [3:0]  idx;
    logic [4:0]  rot;
    logic        prev_en, ph, accept, pass, n, z, c, v;
    logic        is_b, is_ls, is_dp, mov, need_rn, need_rm, need_rd, rd_state;

    assign {n, z, c, v} = cpsr_flags;
    assign accept     = state == IDLE && decode_en && !prev_en;
    assign is_b       = ir[27:25] == 3'b101;
    assign is_ls      = ir[27:26] == 2'b01;
    assign is_dp      = ir[27:26] == 2'b00 && (ir[25] || !ir[4]);
    assign mov        = ir[24:21] == 4'b1101 || ir[24:21] == 4'b1111;
    assign need_rn    = is_b || is_ls || (is_dp && !mov);
    assign need_rm    = (is_dp && !ir[25]) || (is_ls && ir[25]);
    assign need_rd    = is_ls && !ir[20];
    assign after_rm   = need_rd ? RD_RD : ISSUE;
    assign after_rn   = need_rm ? RD_RM : after_rm;
    assign after_cond = need_rn ? RD_RN : after_rn;
    assign rd_state   = state == RD_RN || state == RD_RM || state == RD_RD;
    assign idx        = state == RD_RN ? (is_b ? 4'hf : ir[19:16]) : state == RD_RM ? ir[3:0] : ir[15:12];
    assign rdata      = reg_read_value + (idx == 4'hf ? PC_OFFSET : 32'd0);
    // bypass the value being sampled on the edge that enters ISSUE
    assign rn_v       = state == RD_RN && ph ? rdata : rn_val;
    assign rm_v       = state == RD_RM && ph ? rdata : rm_val;
    assign rd_v       = state == RD_RD && ph ? rdata : rd_val;
    assign imm        = {24'd0, ir[7:0]};
    assign rot        = {ir[11:8], 1'b0};
    assign rot_imm    = (imm >> rot) | (imm << (6'd32 - {1'b0, rot}));
    assign boff       = {{6{ir[23]}}, ir[23:0], 2'b00};
    assign op2        = is_b ? boff : is_ls ? (ir[25] ? rm_v : {20'd0, ir[11:0]}) :
                        is_dp ? (ir[25] ? rot_imm : rm_v) : 32'd0;

    always_comb begin
        pass = 1'b0;
        case (ir[31:28])
            4'h0: pass = z;
            4'h1: pass = !z;
            4'h2: pass = c;
            4'h3: pass = !c;
            4'h4: pass = n;
            4'h5: pass = !n;
            4'h6: pass = v;
            4'h7: pass = !v;
            4'h8: pass = c && !z;
            4'h9: pass = !c || z;
            4'ha: pass = n == v;
            4'hb: pass = n != v;
            4'hc: pass = !z && n == v;
            4'hd: pass = z || n != v;
            4'he: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = accept ? COND : IDLE;
            COND:    nxt = pass ? after_cond : RELEASE;
            RD_RN:   nxt = ph ? after_rn : RD_RN;
            RD_RM:   nxt = ph ? after_rm : RD_RM;
            RD_RD:   nxt = ph ? ISSUE : RD_RD;
            ISSUE:   nxt = exec_busy ? ISSUE : RELEASE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = state != IDLE;
        reg_read_en  = rd_state && !ph;
        reg_read_reg = reg_read_en ? idx : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_en         <= 1'b0;
            ph              <= 1'b0;
            ir              <= '0;
            rn_val          <= '0;
            rm_val          <= '0;
            rd_val          <= '0;
            exec_en         <= 1'b0;
            exec_class      <= '0;
            exec_op         <= '0;
            exec_ctrl       <= '0;
            exec_rd         <= '0;
            exec_op1        <= '0;
            exec_op2        <= '0;
            exec_shift_type <= '0;
            exec_shift_amt  <= '0;
            exec_store_data <= '0;
        end else begin
            prev_en <= decode_en;
            ph      <= rd_state && !ph;
            rn_val  <= rn_v;
            rm_val  <= rm_v;
            rd_val  <= rd_v;
            exec_en <= state == ISSUE && !exec_busy;
            if (accept) ir <= instr;
            if (nxt == ISSUE && state != ISSUE) begin
                exec_class      <= is_b ? 2'd2 : is_ls ? 2'd1 : is_dp ? 2'd0 : 2'd3;
                exec_op         <= ir[24:21];
                exec_ctrl       <= ir[25:20];
                exec_rd         <= ir[15:12];
                exec_op1        <= need_rn ? rn_v : 32'd0;
                exec_op2        <= op2;
                exec_shift_type <= need_rm ? ir[6:5] : (is_dp && ir[25]) ? 2'd3 : 2'd0;
                exec_shift_amt  <= need_rm ? ir[11:7] : 5'd0;
                exec_store_data <= need_rd ? rd_v : 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed vector table, corner sequences and randomized checks against a reference model
module tb_decode;
    logic        clk = 0, rst_n = 0, decode_en = 0, exec_busy = 0;
    logic [31:0] instr = 0, reg_read_value;
    logic [3:0]  cpsr_flags = 0;
    logic        busy, reg_read_en, exec_en;
    logic [3:0]  reg_read_reg, exec_op, exec_rd;
    logic [1:0]  exec_class, exec_shift_type;
    logic [5:0]  exec_ctrl;
    logic [4:0]  exec_shift_amt;
    logic [31:0] exec_op1, exec_op2, exec_store_data;

    decode dut (
        .clk(clk), .rst_n(rst_n), .decode_en(decode_en), .instr(instr), .cpsr_flags(cpsr_flags),
        .busy(busy), .reg_read_en(reg_read_en), .reg_read_reg(reg_read_reg),
        .reg_read_value(reg_read_value), .exec_en(exec_en), .exec_busy(exec_busy),
        .exec_class(exec_class), .exec_op(exec_op), .exec_ctrl(exec_ctrl), .exec_rd(exec_rd),
        .exec_op1(exec_op1), .exec_op2(exec_op2), .exec_shift_type(exec_shift_type),
        .exec_shift_amt(exec_shift_amt), .exec_store_data(exec_store_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [3:0]  f;
        logic        fire;
        logic [1:0]  cls;
        logic [31:0] op1, op2, st;
        logic [1:0]  stt;
        logic [4:0]  sha;
        logic [11:0] rds;
        int          nr;
    } vec_t;

    int tests = 0, fails = 0, cyc = 0, en_cnt = 0, busy_cyc = 0;
    logic [31:0] regs [16];
    logic [3:0]  rq[$];
    int          rt[$];
    logic [1:0]  cap_cls, cap_stt;
    logic [3:0]  cap_op, cap_rd;
    logic [5:0]  cap_ctrl;
    logic [4:0]  cap_sha;
    logic [31:0] cap_op1, cap_op2, cap_st;

    // register file: data valid only in the cycle two edges after the request edge
    always @(posedge clk) reg_read_value <= reg_read_en ? regs[reg_read_reg] : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cyc++;
        if (reg_read_en) begin
            rq.push_back(reg_read_reg);
            rt.push_back(cyc);
        end
        if (exec_en) begin
            en_cnt++;
            cap_cls = exec_class; cap_op = exec_op; cap_ctrl = exec_ctrl; cap_rd = exec_rd;
            cap_op1 = exec_op1; cap_op2 = exec_op2; cap_st = exec_store_data;
            cap_stt = exec_shift_type; cap_sha = exec_shift_amt;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rv(input logic [3:0] i);
        return regs[i] + (i == 4'hf ? 32'd12 : 32'd0);
    endfunction

    function automatic vec_t model(input logic [31:0] w, input logic [3:0] f);
        vec_t e;
        logic n, z, c, v, pass, b, ls, dp, movf;
        logic [31:0] x;
        logic [3:0] q[$];
        {n, z, c, v} = f;
        case (w[31:28])
            4'h0: pass = z;             4'h1: pass = !z;
            4'h2: pass = c;             4'h3: pass = !c;
            4'h4: pass = n;             4'h5: pass = !n;
            4'h6: pass = v;             4'h7: pass = !v;
            4'h8: pass = c && !z;       4'h9: pass = !c || z;
            4'ha: pass = n == v;        4'hb: pass = n != v;
            4'hc: pass = !z && n == v;  4'hd: pass = z || n != v;
            4'he: pass = 1;             default: pass = 0;
        endcase
        e = '{w: w, f: f, fire: pass, cls: 0, op1: 0, op2: 0, st: 0, stt: 0, sha: 0, rds: 0, nr: 0};
        if (!pass) return e;
        b = w[27:25] == 3'b101;
        ls = w[27:26] == 2'b01;
        dp = w[27:26] == 2'b00 && !(w[25] == 0 && w[4] == 1);
        movf = w[24:21] == 4'd13 || w[24:21] == 4'd15;
        e.cls = b ? 2'd2 : ls ? 2'd1 : dp ? 2'd0 : 2'd3;
        if (b) q.push_back(4'hf);
        else if (dp) begin
            if (!movf) q.push_back(w[19:16]);
            if (!w[25]) q.push_back(w[3:0]);
        end else if (ls) begin
            q.push_back(w[19:16]);
            if (w[25]) q.push_back(w[3:0]);
            if (!w[20]) q.push_back(w[15:12]);
        end
        e.nr = q.size();
        foreach (q[i]) e.rds[4*(2-i) +: 4] = q[i];
        if (b) e.op1 = rv(4'hf);
        else if ((dp && !movf) || ls) e.op1 = rv(w[19:16]);
        if (b) begin
            x = {{8{w[23]}}, w[23:0]};
            e.op2 = x * 4;
        end else if (dp && w[25]) begin
            x = {24'd0, w[7:0]};
            for (int k = 0; k < 2 * w[11:8]; k++) x = {x[0], x[31:1]};
            e.op2 = x;
            e.stt = 3;
        end else if (dp || (ls && w[25])) begin
            e.op2 = rv(w[3:0]);
            e.stt = w[6:5];
            e.sha = w[11:7];
        end else if (ls) e.op2 = {20'd0, w[11:0]};
        if (ls && !w[20]) e.st = rv(w[15:12]);
        return e;
    endfunction

    task automatic run(input logic [31:0] w, input logic [3:0] f, input int bsy, input int hold);
        int done = 0, seen = 0;
        tick;
        instr = w; cpsr_flags = f; decode_en = 1; exec_busy = bsy > 0;
        rq.delete(); rt.delete(); en_cnt = 0; busy_cyc = 0;
        for (int i = 0; i < 60 && done == 0; i++) begin
            tick;
            if (i + 1 >= bsy) exec_busy = 0;
            if (busy) seen = 1;
            else if (seen != 0) done = 1;
        end
        chk("txn_done", 32'(done), 32'd1);
        repeat (hold) tick;
        decode_en = 0;
        tick;
    endtask

    task automatic check_txn(input vec_t e, input int bsy);
        chk("exec_en_count", 32'(en_cnt), 32'(e.fire));
        chk("read_count", 32'(rq.size()), 32'(e.nr));
        for (int i = 0; i < e.nr && i < rq.size(); i++) chk("read_idx", 32'(rq[i]), 32'(e.rds[4*(2-i) +: 4]));
        for (int i = 1; i < rt.size(); i++) chk("read_gap", 32'(rt[i] - rt[i-1]), 32'd2);
        if (bsy == 0) chk("busy_cycles", 32'(busy_cyc), e.fire ? 32'(3 + 2 * e.nr) : 32'd2);
        chk("busy_end", 32'(busy), 32'd0);
        if (e.fire && en_cnt == 1) begin
            chk("class", 32'(cap_cls), 32'(e.cls));
            chk("op", 32'(cap_op), 32'(e.w[24:21]));
            chk("ctrl", 32'(cap_ctrl), 32'(e.w[25:20]));
            chk("rd", 32'(cap_rd), 32'(e.w[15:12]));
            chk("op1", cap_op1, e.op1);
            chk("op2", cap_op2, e.op2);
            chk("store_data", cap_st, e.st);
            chk("shift_type", 32'(cap_stt), 32'(e.stt));
            chk("shift_amt", 32'(cap_sha), 32'(e.sha));
        end
    endtask

    vec_t tv[11];

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        int bsy, done;
        foreach (regs[i]) regs[i] = 0;
        regs[1] = 32'h1000; regs[2] = 5; regs[3] = 32'hAB; regs[4] = 32'h20; regs[5] = 4; regs[15] = 32'h100;
        //         instr          flags    fire cls op1            op2            st        stt sha rds     nr
        tv[0]  = '{32'h028214FF, 4'b0100, 1, 0, 32'h5,         32'hFF000000, 0,         3, 0, 12'h200, 1};
        tv[1]  = '{32'h028214FF, 4'b0000, 0, 0, 0,             0,            0,         0, 0, 12'h000, 0};
        tv[2]  = '{32'hEAFFFFFE, 4'b0000, 1, 2, 32'h10C,       32'hFFFFFFF8, 0,         0, 0, 12'hF00, 1};
        tv[3]  = '{32'hE7843005, 4'b0000, 1, 1, 32'h20,        32'h4,        32'hAB,    0, 0, 12'h453, 3};
        tv[4]  = '{32'hE3A00001, 4'b0000, 1, 0, 0,             32'h1,        0,         3, 0, 12'h000, 0};
        tv[5]  = '{32'hE0810312, 4'b0000, 1, 3, 0,             0,            0,         0, 0, 12'h000, 0};
        tv[6]  = '{32'hE5910010, 4'b0000, 1, 1, 32'h1000,      32'h10,       0,         0, 0, 12'h100, 1};
        tv[7]  = '{32'hF3A00001, 4'b1111, 0, 0, 0,             0,            0,         0, 0, 12'h000, 0};
        tv[8]  = '{32'hE08F0001, 4'b0000, 1, 0, 32'h10C,       32'h1000,     0,         0, 0, 12'hF10, 2};
        tv[9]  = '{32'hC3A00005, 4'b0000, 1, 0, 0,             32'h5,        0,         3, 0, 12'h000, 0};
        tv[10] = '{32'hD3A00005, 4'b0000, 0, 0, 0,             0,            0,         0, 0, 12'h000, 0};

        repeat (3) tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_read_en", 32'(reg_read_en), 0);
        chk("rst_exec_en", 32'(exec_en), 0);
        chk("rst_op2", exec_op2, 0);
        rst_n = 1;
        tick;

        foreach (tv[i]) begin
            run(tv[i].w, tv[i].f, 0, i == 3 ? 10 : 0);
            check_txn(tv[i], 0);
        end

        // exec_busy stall: fields stable and no issue until it drops
        tick;
        instr = 32'hE7843005; cpsr_flags = 0; decode_en = 1; exec_busy = 1;
        rq.delete(); rt.delete(); en_cnt = 0;
        for (int i = 0; i < 40 && rq.size() < 3; i++) tick;
        tick;
        repeat (5) begin
            tick;
            chk("stall_exec_en", 32'(exec_en), 0);
            chk("stall_op2", exec_op2, 32'h4);
            chk("stall_store", exec_store_data, 32'hAB);
        end
        exec_busy = 0;
        done = 0;
        for (int i = 0; i < 20 && done == 0; i++) begin
            tick;
            if (!busy) done = 1;
        end
        chk("stall_done", 32'(done), 1);
        chk("stall_en_count", 32'(en_cnt), 1);
        chk("stall_op1", cap_op1, 32'h20);
        decode_en = 0;
        tick;

        // reset while reading Rm
        instr = 32'hE7843005; decode_en = 1;
        done = 0;
        for (int i = 0; i < 20 && done == 0; i++) begin
            tick;
            if (reg_read_en && reg_read_reg == 4'd5) done = 1;
        end
        chk("reach_rd_rm", 32'(done), 1);
        rst_n = 0;
        en_cnt = 0;
        tick;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_read_en", 32'(reg_read_en), 0);
        chk("mid_rst_read_reg", 32'(reg_read_reg), 0);
        chk("mid_rst_op1", exec_op1, 0);
        chk("mid_rst_store", exec_store_data, 0);
        chk("mid_rst_class", 32'(exec_class), 0);
        rst_n = 1;
        decode_en = 0;
        tick;
        chk("mid_rst_no_issue", 32'(en_cnt), 0);
        run(tv[0].w, tv[0].f, 0, 0);
        check_txn(tv[0], 0);

        // randomized instructions against the reference model
        for (int t = 0; t < 40; t++) begin
            foreach (regs[i]) regs[i] = $urandom;
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w[27:25] = 3'b101;
                1: w[27:26] = 2'b01;
                2: w[27:26] = 2'b00;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) w[31:28] = 4'he;
            bsy = $urandom_range(0, 3);
            cpsr_flags = 4'($urandom);
            run(w, cpsr_flags, bsy, 0);
            check_txn(model(w, cpsr_flags), bsy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
